// File: rtl/jedro_1_ifu_pkg.sv
// Shared definitions for the jedro_1 fetch path: default widths, boot address
// and the (instr, pc) entry carried from the prefetch FIFO to the decoder.
package jedro_1_defines;

    localparam int unsigned         DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned         DEFAULT_ADDR_WIDTH = 32;
    localparam logic [31:0]         DEFAULT_BOOT_ADDR  = 32'h0000_0000;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] instr;
        logic [DEFAULT_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/jedro_1_fifo.sv
// Prefetch FIFO of fetch entries. flush overrides push and pop; head is zero
// while the FIFO is empty.
module jedro_1_fifo
    import jedro_1_defines::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  fetch_entry_t                 entry_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output fetch_entry_t                 head_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = entry_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/jedro_1_ifu.sv
// Instruction fetch unit: sequential word fetch from a 1-cycle ROM into a
// prefetch FIFO, with jump redirect flushing buffered and in-flight words.
module jedro_1_ifu
    import jedro_1_defines::*;
#(
    parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_en_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic                  jmp_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                  inflight_q, inflight_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full_unused;
    logic                  fifo_push;
    logic                  fifo_pop;
    fetch_entry_t          fifo_head;
    fetch_entry_t          fifo_entry;
    logic                  jmp_addr_unused;

    assign jmp_addr_unused = ^jmp_addr_i[1:0];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        // Credit counts only registered occupancy; a same-cycle pop frees nothing.
        imem_en_o     = !rst_i && !jmp_i &&
                        ((fifo_count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
        inflight_d    = imem_en_o;
        if (jmp_i) begin
            fetch_pc_d = {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (imem_en_o) begin
            fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= BOOT_ADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign imem_addr_o = fetch_pc_q;
    assign fifo_push   = inflight_q && !jmp_i;
    assign fifo_pop    = valid_o && ready_i;
    assign fifo_entry  = '{instr: imem_rdata_i, pc: inflight_pc_q};

    jedro_1_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .entry_i (fifo_entry),
        .pop_i   (fifo_pop),
        .flush_i (jmp_i),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign valid_o = !fifo_empty;
    assign instr_o = fifo_head.instr;
    assign pc_o    = fifo_head.pc;

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Bench for jedro_1_ifu: ROM responder, directed timing scenarios, randomized
// ready/jump/reset traffic, and a scoreboard checking the delivered stream.
module tb_jedro_1_ifu;
    import jedro_1_defines::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        jmp_i = 1'b0;
    logic [31:0] jmp_addr_i = '0;

    int checks = 0;
    int errors = 0;
    int handshakes = 0;

    always #5 clk = ~clk;

    jedro_1_ifu #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_en_o    (imem_en_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .jmp_i        (jmp_i),
        .jmp_addr_i   (jmp_addr_i)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0010_0093;
            32'h4:   return 32'h0020_0113;
            32'h8:   return 32'h0020_81B3;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    // Synchronous single-cycle ROM
    always @(posedge clk) begin
        if (imem_en_o) imem_rdata_i <= rom(imem_addr_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the delivered PC stream is sequential from the last
    // redirect point (reset -> BOOT, jump -> aligned target).
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_pc, prev_instr;

    task automatic redirect(input logic [31:0] start);
        exp_q.delete();
        gen_pc = start;
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (hold_prev) begin
            check("hold_valid", {31'b0, valid_o}, 32'd1);
            check("hold_pc", pc_o, prev_pc);
            check("hold_instr", instr_o, prev_instr);
        end
        if (!valid_o) begin
            check("empty_pc_zero", pc_o, 32'h0);
            check("empty_instr_zero", instr_o, 32'h0);
        end
        if (valid_o && ready_i && !rst_i) begin
            while (exp_q.size() < 8) begin
                exp_q.push_back(gen_pc);
                gen_pc = gen_pc + 32'd4;
            end
            e = exp_q.pop_front();
            check("stream_pc", pc_o, e);
            check("stream_instr", instr_o, rom(e));
            handshakes++;
        end
        if (rst_i)      redirect(BOOT);
        else if (jmp_i) redirect({jmp_addr_i[31:2], 2'b00});
        hold_prev  = valid_o && !ready_i && !jmp_i && !rst_i;
        prev_pc    = pc_o;
        prev_instr = instr_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller at the start of cycle 0 (first cycle with rst_i low).
    task automatic do_reset(input logic rdy);
        rst_i = 1'b1;
        jmp_i = 1'b0;
        ready_i = 1'b0;
        tick();
        @(negedge clk);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_en", {31'b0, imem_en_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        ready_i = rdy;
    endtask

    initial begin
        int nreq;

        // Basic fill and back-to-back delivery
        do_reset(1'b1);
        @(negedge clk);
        check("c0_en", {31'b0, imem_en_o}, 32'd1);
        check("c0_addr", imem_addr_o, BOOT);
        check("c0_valid", {31'b0, valid_o}, 32'd0);
        tick(); @(negedge clk);
        check("c1_valid", {31'b0, valid_o}, 32'd0);
        tick(); @(negedge clk);
        check("c2_valid", {31'b0, valid_o}, 32'd1);
        check("c2_pc", pc_o, 32'h0);
        check("c2_instr", instr_o, 32'h0010_0093);
        tick(); @(negedge clk);
        check("c3_pc", pc_o, 32'h4);
        check("c3_instr", instr_o, 32'h0020_0113);
        tick(); @(negedge clk);
        check("c4_pc", pc_o, 32'h8);
        check("c4_instr", instr_o, 32'h0020_81B3);

        // Back-pressure: exactly DEPTH requests while ready_i is low
        do_reset(1'b0);
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_en_o) begin
                check("bp_addr", imem_addr_o, 32'(nreq * 4));
                nreq++;
            end
            tick();
        end
        check("bp_req_count", 32'(nreq), 32'(DEPTH));
        @(negedge clk);
        check("bp_en_stopped", {31'b0, imem_en_o}, 32'd0);
        tick();
        ready_i = 1'b1;
        repeat (12) tick();

        // Jump with 3 buffered entries and one in flight; low bits ignored
        do_reset(1'b0);
        repeat (4) tick();
        jmp_i = 1'b1;
        jmp_addr_i = 32'h43;
        @(negedge clk);
        check("jf_valid_before", {31'b0, valid_o}, 32'd1);
        check("jf_en", {31'b0, imem_en_o}, 32'd0);
        tick();
        jmp_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        check("j1_valid", {31'b0, valid_o}, 32'd0);
        check("j1_en", {31'b0, imem_en_o}, 32'd1);
        check("j1_addr", imem_addr_o, 32'h40);
        tick(); @(negedge clk);
        check("j2_valid", {31'b0, valid_o}, 32'd0);
        tick(); @(negedge clk);
        check("j3_valid", {31'b0, valid_o}, 32'd1);
        check("j3_pc", pc_o, 32'h40);
        tick();

        // Wrap at the top of the address space
        jmp_i = 1'b1;
        jmp_addr_i = 32'hFFFF_FFF8;
        tick();
        jmp_i = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("wrap_pc0", pc_o, 32'hFFFF_FFF8);
        tick(); @(negedge clk);
        check("wrap_pc1", pc_o, 32'hFFFF_FFFC);
        tick(); @(negedge clk);
        check("wrap_pc2", pc_o, 32'h0);
        check("wrap_instr2", instr_o, 32'h0010_0093);
        tick();

        // Single-cycle reset pulse with 2 entries buffered
        do_reset(1'b0);
        repeat (3) tick();
        @(negedge clk);
        check("mr_valid_before", {31'b0, valid_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        check("mr0_valid", {31'b0, valid_o}, 32'd0);
        check("mr0_en", {31'b0, imem_en_o}, 32'd1);
        check("mr0_addr", imem_addr_o, BOOT);
        tick(); @(negedge clk);
        check("mr1_valid", {31'b0, valid_o}, 32'd0);
        tick(); @(negedge clk);
        check("mr2_valid", {31'b0, valid_o}, 32'd1);
        check("mr2_pc", pc_o, BOOT);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            ready_i = ($urandom_range(9) < 7);
            jmp_i   = ($urandom_range(19) == 0);
            rst_i   = ($urandom_range(199) == 0);
            case ($urandom_range(2))
                0:       jmp_addr_i = $urandom_range(255);
                1:       jmp_addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                default: jmp_addr_i = $urandom;
            endcase
            tick();
        end
        rst_i = 1'b0;
        jmp_i = 1'b0;
        ready_i = 1'b1;
        repeat (10) tick();
        check("handshake_volume", {31'b0, handshakes > 1000}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
